// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: three-stage pipelined add/subtract unit for sign-magnitude
// operands, with valid/ready flow control and a pass-through tag.
//
// Parameters:
//   WIDTH  operand/result width including the sign bit (4..64)
//   TAG_W  width of the user tag carried with each operation (1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented on op1/op2/sub/in_tag
//   in_ready   operation accepted this cycle (combinational, independent of in_valid)
//   op1, op2   sign-magnitude operands (MSB = sign)
//   sub        0: op1+op2, 1: op1-op2
//   in_tag     user tag, returned unchanged alongside the result
//   out_valid  result valid (registered)
//   out_ready  consumer accepts the result
//   res        sign-magnitude result (registered)
//   ovf        true result magnitude exceeds 2^(WIDTH-1)-1 (registered)
//   zero       true result equals zero (registered)
//   out_tag    tag of the operation currently on res (registered)
//
// Build option:
//   SM_ADDSUB_SAT_EN  when defined, overflowing results saturate to
//                     {sign, all-ones magnitude}; otherwise the magnitude wraps.

module sm_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  // Two's-complement width: one extra bit so |a+b| <= 2^WIDTH-2 never wraps.
  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned MW = WIDTH - 1;

  // Sign-magnitude to two's complement; negative zero maps to zero.
  function automatic logic [XW-1:0] to_tc(input logic [WIDTH-1:0] x);
    logic [XW-1:0] m;
    m = {2'b00, x[MW-1:0]};
    return x[WIDTH-1] ? -m : m;
  endfunction

  // Stage valids and advance enables
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  // Stage data
  logic [XW-1:0]    a1, b1;
  logic [TAG_W-1:0] tag1;
  logic [XW-1:0]    sum2;
  logic [TAG_W-1:0] tag2;

  // Combinational stage results
  logic [XW-1:0]    a_c, b_c, op2_tc;
  logic             neg_c;
  logic [WIDTH-1:0] mag_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             zero_c;

  // Bubble-collapsing flow control: a stage advances if empty or its successor advances.
  always_comb begin
    adv3 = ~v3 | out_ready;
    adv2 = ~v2 | adv3;
    adv1 = ~v1 | adv2;
  end

  assign in_ready  = adv1;
  assign out_valid = v3;

  // S1: convert operands, negating op2 for subtraction
  always_comb begin
    a_c    = to_tc(op1);
    op2_tc = to_tc(op2);
    b_c    = sub ? -op2_tc : op2_tc;
  end

  // S3: back to sign-magnitude; a zero sum has sign 0, so zero is never emitted negative
  always_comb begin
    neg_c  = sum2[WIDTH];
    mag_c  = neg_c ? WIDTH'(-sum2) : sum2[WIDTH-1:0];
    ovf_c  = mag_c[WIDTH-1];
    zero_c = (sum2 == '0);
`ifdef SM_ADDSUB_SAT_EN
    res_c  = ovf_c ? {neg_c, {MW{1'b1}}} : {neg_c, mag_c[MW-1:0]};
`else
    res_c  = {neg_c, mag_c[MW-1:0]};
`endif
  end

  // Pipeline registers; data only loads when a valid operation moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      a1      <= '0;
      b1      <= '0;
      tag1    <= '0;
      sum2    <= '0;
      tag2    <= '0;
      res     <= '0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      out_tag <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1   <= a_c;
          b1   <= b_c;
          tag1 <= in_tag;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          sum2 <= a1 + b1;
          tag2 <= tag1;
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          res     <= res_c;
          ovf     <= ovf_c;
          zero    <= zero_c;
          out_tag <= tag2;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Testbench for sm_addsub_pipe: directed vectors on an 8-bit instance and a
// back-to-back random stream on a 32-bit instance against a signed-integer model.

module tb_sm_addsub_pipe;

`ifdef SM_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, ovf8, zero8;
  logic [7:0] op1_8, op2_8, res8;
  logic [3:0] in_tag8, out_tag8;

  logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, ovf32, zero32;
  logic [31:0] op1_32, op2_32, res32;
  logic [3:0]  in_tag32, out_tag32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .sub(sub8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .res(res8), .ovf(ovf8), .zero(zero8), .out_tag(out_tag8)
  );

  sm_addsub_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .op1(op1_32), .op2(op2_32), .sub(sub32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .res(res32), .ovf(ovf32), .zero(zero32), .out_tag(out_tag32)
  );

  // Signed-integer reference for a w-bit sign-magnitude add/sub.
  function automatic logic [63:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic s,
                                        output logic o, output logic z);
    longint lim, ma, mb, va, vb, r, mag, mo;
    lim = (longint'(1) <<< (w - 1)) - 1;
    ma  = longint'(a) & lim;
    mb  = longint'(b) & lim;
    va  = a[w-1] ? -ma : ma;
    vb  = b[w-1] ? -mb : mb;
    r   = s ? (va - vb) : (va + vb);
    mag = (r < 0) ? -r : r;
    o   = (mag > lim);
    z   = (r == 0);
    mo  = o ? (SAT ? lim : (mag & lim)) : mag;
    return 64'(mo) | ((r < 0) ? 64'(lim + 1) : 64'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 1'b0; op1_8 = '0; op2_8 = '0; sub8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; op1_32 = '0; op2_32 = '0; sub32 = 1'b0; in_tag32 = '0; out_ready32 = 1'b1;
    step();
    step();
    checks++;
    if ({out_valid8, res8, ovf8, zero8, out_tag8} !== 15'd0)
      begin errors++; $display("FAIL reset_out8: got %h expected 0", {out_valid8, res8, ovf8, zero8, out_tag8}); end
    checks++;
    if ({out_valid32, res32, ovf32, zero32, out_tag32} !== 39'd0)
      begin errors++; $display("FAIL reset_out32: got %h expected 0", {out_valid32, res32, ovf32, zero32, out_tag32}); end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready8, in_ready32} !== 2'b11)
      begin errors++; $display("FAIL reset_in_ready: got %b expected 11", {in_ready8, in_ready32}); end
    step();
  endtask

  // One operation through the 8-bit unit with out_ready held high.
  task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [3:0] tag, input logic [7:0] eres,
                         input logic eovf, input logic ezero);
    int lat;
    op1_8 = a; op2_8 = b; sub8 = s; in_tag8 = tag; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1)
      begin errors++; $display("FAIL %s_ready: got %b expected 1", name, in_ready8); end
    step();
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 3)
      begin errors++; $display("FAIL %s_latency: got %0d expected 3", name, lat); end
    checks++;
    if ({res8, ovf8, zero8, out_tag8} !== {eres, eovf, ezero, tag})
      begin errors++; $display("FAIL %s: got res=%h ovf=%b zero=%b tag=%h expected res=%h ovf=%b zero=%b tag=%h",
                               name, res8, ovf8, zero8, out_tag8, eres, eovf, ezero, tag); end
    step();
  endtask

  task automatic test_directed();
    test_op("sub_pos",    8'h05, 8'h03, 1'b1, 4'd1, 8'h02, 1'b0, 1'b0);
    test_op("sub_neg",    8'h03, 8'h05, 1'b1, 4'd2, 8'h82, 1'b0, 1'b0);
    test_op("add_cancel", 8'h85, 8'h05, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1);
    test_op("neg_zero",   8'h80, 8'h00, 1'b1, 4'd4, 8'h00, 1'b0, 1'b1);
    test_op("add_ff_7f",  8'hFF, 8'h7F, 1'b0, 4'd5, 8'h00, 1'b0, 1'b1);
    test_op("ovf_pos",    8'h7F, 8'h01, 1'b0, 4'd6, SAT ? 8'h7F : 8'h00, 1'b1, 1'b0);
    test_op("ovf_neg",    8'hFF, 8'h01, 1'b1, 4'd7, SAT ? 8'hFF : 8'h80, 1'b1, 1'b0);
    test_op("add_negs",   8'h83, 8'h81, 1'b0, 4'd8, 8'h84, 1'b0, 1'b0);
    test_op("add_negz2",  8'h05, 8'h80, 1'b0, 4'd9, 8'h05, 1'b0, 1'b0);
  endtask

  // 1000 random ops on the 32-bit unit, one per cycle, scoreboarded in order.
  task automatic test_back_to_back();
    logic [37:0] exp_q[$];
    logic [37:0] exp;
    logic [63:0] m;
    logic o, z;
    int sent, got, cyc, first_cyc, gaps;
    sent = 0; got = 0; cyc = 0; first_cyc = -1; gaps = 0;
    out_ready32 = 1'b1;
    while ((sent < 1000 || got < 1000) && cyc < 1200) begin
      if (sent < 1000) begin
        op1_32 = $urandom;
        op2_32 = $urandom;
        if ($urandom_range(0, 3) == 0) op1_32[30:8] = '0;
        if ($urandom_range(0, 3) == 0) op2_32[30:8] = '0;
        sub32 = 1'($urandom_range(0, 1));
        in_tag32 = 4'($urandom_range(0, 15));
        in_valid32 = 1'b1;
      end else begin
        in_valid32 = 1'b0;
      end
      #1;
      if (in_valid32) begin
        checks++;
        if (in_ready32 !== 1'b1)
          begin errors++; $display("FAIL b2b_in_ready: got %b expected 1 at cycle %0d", in_ready32, cyc); end
      end
      if (out_valid32 === 1'b1) begin
        if (got == 0) first_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got unexpected result %h expected none", res32);
        end else begin
          exp = exp_q.pop_front();
          if ({res32, ovf32, zero32, out_tag32} !== exp)
            begin errors++; $display("FAIL b2b_result: got %h expected %h (op %0d)",
                                     {res32, ovf32, zero32, out_tag32}, exp, got); end
        end
        got++;
      end else if (got > 0 && got < 1000) begin
        gaps++;
      end
      if (in_valid32 && in_ready32) begin
        m = model(32, {32'd0, op1_32}, {32'd0, op2_32}, sub32, o, z);
        exp_q.push_back({m[31:0], o, z, in_tag32});
        sent++;
      end
      step();
      cyc++;
    end
    in_valid32 = 1'b0;
    checks++;
    if (got !== 1000) begin errors++; $display("FAIL b2b_count: got %0d expected 1000", got); end
    checks++;
    if (first_cyc !== 3) begin errors++; $display("FAIL b2b_fill: got %0d expected 3", first_cyc); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
  endtask

  // Stall with tags 1..4 queued, then drain with out_ready toggling.
  task automatic test_backpressure();
    int accepted, got, cyc, extra;
    logic tog;
    accepted = 0;
    out_ready8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (accepted < 4) begin
        in_valid8 = 1'b1; in_tag8 = 4'(accepted + 1);
        op1_8 = 8'(accepted + 1); op2_8 = 8'h10; sub8 = 1'b0;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (in_valid8 && in_ready8) accepted++;
      step();
    end
    #1;
    checks++;
    if (accepted !== 3) begin errors++; $display("FAIL bp_accepts: got %0d expected 3", accepted); end
    checks++;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready8); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid8, out_tag8, res8, ovf8, zero8} !== {1'b1, 4'd1, 8'h11, 1'b0, 1'b0})
        begin errors++; $display("FAIL bp_hold: got v=%b tag=%h res=%h expected v=1 tag=1 res=11",
                                 out_valid8, out_tag8, res8); end
      step();
    end
    got = 0; cyc = 0; tog = 1'b1;
    while (got < 4 && cyc < 30) begin
      out_ready8 = tog;
      tog = ~tog;
      if (accepted < 4) begin
        in_valid8 = 1'b1; in_tag8 = 4'd4; op1_8 = 8'h04; op2_8 = 8'h10; sub8 = 1'b0;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (in_valid8 && in_ready8) accepted++;
      if (out_valid8 && out_ready8) begin
        checks++;
        if ({out_tag8, res8} !== {4'(got + 1), 8'(got + 8'h11)})
          begin errors++; $display("FAIL bp_order: got tag=%h res=%h expected tag=%h res=%h",
                                   out_tag8, res8, 4'(got + 1), 8'(got + 8'h11)); end
        got++;
      end
      step();
      cyc++;
    end
    in_valid8 = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL bp_drain: got %0d results expected 4", got); end
    out_ready8 = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid8 === 1'b1) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
  endtask

  // Two ops in flight are discarded by a one-cycle reset.
  task automatic test_reset_midflight();
    int seen;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; op1_8 = 8'h01; op2_8 = 8'h01; sub8 = 1'b0; in_tag8 = 4'd9;
    step();
    in_tag8 = 4'd10; op1_8 = 8'h02;
    step();
    in_valid8 = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({out_valid8, res8} !== 9'd0)
      begin errors++; $display("FAIL mid_reset_out: got v=%b res=%h expected v=0 res=00", out_valid8, res8); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", in_ready8); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_reset_ghost: got %0d results expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
